io_port_bank: RTL and testbench

- Parametrised multi-channel I/O port block; the next generation of the core's single 8-bit i_in/o_out pair.
- Provides NUM_CH channels of DATA_W bits. Each channel has a registered output latch, a synchronised input, sticky change-detect flags and a maskable interrupt.
- Sits between the core's load/store path and the top-level pins.
- Accessed through a simple single-cycle register bus with 1-cycle read latency.

---
 rtl/io_port_bank.sv | 119 +++++++++++
 tb/tb_io_port_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// Multi-channel I/O port bank: output latches, synchronised inputs,
// sticky change flags, maskable interrupt, single-cycle register bus.
module io_port_bank #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH*DATA_W-1:0] i_in,
  output logic [NUM_CH*DATA_W-1:0] o_out,
  input  logic [CH_W-1:0]          i_ch,
  input  logic [1:0]               i_reg,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_rvalid,
  output logic                     o_irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SYNC_STAGES + 1);

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_CHG  = 2'd2;
  localparam logic [1:0] REG_MASK = 2'd3;

  logic [DATA_W-1:0] r_sync [NUM_CH][SYNC_STAGES];
  logic [DATA_W-1:0] r_out  [NUM_CH];
  logic [DATA_W-1:0] r_prev [NUM_CH];
  logic [DATA_W-1:0] r_chg  [NUM_CH];
  logic [DATA_W-1:0] r_mask [NUM_CH];
  logic [CNT_W-1:0]  r_settle;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  logic [NUM_CH-1:0] w_sel;
  logic [DATA_W-1:0] w_clr  [NUM_CH];
  logic [DATA_W-1:0] w_tog  [NUM_CH];
  logic [DATA_W-1:0] w_rsel;
  logic              w_irq;
  logic              w_settled;

  assign w_settled = (r_settle == '0);

  // Out-of-range channels match no w_sel bit, so they read 0 and drop writes.
  always_comb begin
    w_sel  = '0;
    w_rsel = '0;
    w_irq  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c] = (i_ch == CH_W'(c));
      w_clr[c] = '0;
      w_tog[c] = '0;
      if (i_wr_en && w_sel[c] && (i_reg == REG_CHG))
        w_clr[c] = i_wdata;
      if (w_settled)
        w_tog[c] = r_sync[c][SYNC_STAGES-1] ^ r_prev[c];
      if (w_sel[c]) begin
        unique case (i_reg)
          REG_OUT:  w_rsel = r_out[c];
          REG_IN:   w_rsel = r_sync[c][SYNC_STAGES-1];
          REG_CHG:  w_rsel = r_chg[c];
          REG_MASK: w_rsel = r_mask[c];
        endcase
      end
      w_irq = w_irq | (|(r_chg[c] & r_mask[c]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < SYNC_STAGES; s++)
          r_sync[c][s] <= '0;
        r_out[c]  <= '0;
        r_prev[c] <= '0;
        r_chg[c]  <= '0;
        r_mask[c] <= '0;
      end
      r_settle <= LP_SETTLE;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (!w_settled)
        r_settle <= r_settle - 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sync[c][0] <= i_in[c*DATA_W +: DATA_W];
        for (int s = 1; s < SYNC_STAGES; s++)
          r_sync[c][s] <= r_sync[c][s-1];
        r_prev[c] <= r_sync[c][SYNC_STAGES-1];
        // A fresh toggle wins over a same-cycle clear.
        r_chg[c] <= (r_chg[c] & ~w_clr[c]) | w_tog[c];
        if (i_wr_en && w_sel[c] && (i_reg == REG_OUT))
          r_out[c] <= i_wdata;
        if (i_wr_en && w_sel[c] && (i_reg == REG_MASK))
          r_mask[c] <= i_wdata;
      end
      r_rvalid <= i_rd_en;
      if (i_rd_en)
        r_rdata <= w_rsel;
      r_irq <= w_irq;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign o_out[g*DATA_W +: DATA_W] = r_out[g];
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_irq    = r_irq;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: vector table plus hand-written
// multi-cycle sequences for settle, change detect, IRQ and range checks.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic [15:0] out;
  logic        ch;
  logic [1:0]  rg;
  logic        wr;
  logic [7:0]  wd;
  logic        rd;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        irq;

  logic [11:0] p_in;
  logic [11:0] p_out;
  logic [1:0]  p_ch;
  logic [1:0]  p_rg;
  logic        p_wr;
  logic [3:0]  p_wd;
  logic        p_rd;
  logic [3:0]  p_rdata;
  logic        p_rvalid;
  logic        p_irq;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  io_port_bank u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (in),
    .o_out    (out),
    .i_ch     (ch),
    .i_reg    (rg),
    .i_wr_en  (wr),
    .i_wdata  (wd),
    .i_rd_en  (rd),
    .o_rdata  (rdata),
    .o_rvalid (rvalid),
    .o_irq    (irq)
  );

  io_port_bank #(.DATA_W(4), .NUM_CH(3), .SYNC_STAGES(2)) u_p3 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (p_in),
    .o_out    (p_out),
    .i_ch     (p_ch),
    .i_reg    (p_rg),
    .i_wr_en  (p_wr),
    .i_wdata  (p_wd),
    .i_rd_en  (p_rd),
    .o_rdata  (p_rdata),
    .o_rvalid (p_rvalid),
    .o_irq    (p_irq)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic        ch;
    logic [1:0]  rg;
    logic [7:0]  wd;
    logic        rv;
    logic [7:0]  rdx;
    logic [15:0] outx;
  } vec_t;

  vec_t tbl [14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic acc(input logic w, input logic r, input logic c,
                     input logic [1:0] g, input logic [7:0] d);
    wr = w;
    rd = r;
    ch = c;
    rg = g;
    wd = d;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 8'hA5, 0, 8'hFF, 16'hA500};
    tbl[1]  = '{0, 1, 1, 0, 8'h00, 1, 8'hA5, 16'hA500};
    tbl[2]  = '{1, 0, 0, 0, 8'h11, 0, 8'hA5, 16'hA511};
    tbl[3]  = '{1, 1, 0, 0, 8'h22, 1, 8'h11, 16'hA522};
    tbl[4]  = '{0, 1, 0, 0, 8'h00, 1, 8'h22, 16'hA522};
    tbl[5]  = '{1, 0, 1, 3, 8'h3C, 0, 8'h22, 16'hA522};
    tbl[6]  = '{0, 1, 1, 3, 8'h00, 1, 8'h3C, 16'hA522};
    tbl[7]  = '{0, 1, 0, 3, 8'h00, 1, 8'h00, 16'hA522};
    tbl[8]  = '{1, 0, 0, 1, 8'h55, 0, 8'h00, 16'hA522};
    tbl[9]  = '{0, 1, 0, 1, 8'h00, 1, 8'hFF, 16'hA522};
    tbl[10] = '{0, 0, 0, 0, 8'h00, 0, 8'hFF, 16'hA522};
    tbl[11] = '{0, 1, 1, 2, 8'h00, 1, 8'h00, 16'hA522};
    tbl[12] = '{1, 0, 1, 3, 8'h00, 0, 8'h00, 16'hA522};
    tbl[13] = '{0, 1, 1, 3, 8'h00, 1, 8'h00, 16'hA522};

    p_in = '0;
    p_ch = '0;
    p_rg = '0;
    p_wr = 1'b0;
    p_wd = '0;
    p_rd = 1'b0;

    // Reset with a read pending and inputs high.
    rst = 1'b1;
    in  = 16'hFFFF;
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    tick;
    rst = 1'b0;

    // Synchroniser fill must not raise CHG while settling.
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("settle_rvalid", 32'(rvalid), 32'h1);
      chk("settle_chg0", 32'(rdata), 32'h00);
    end
    acc(0, 1, 0, 1, 8'h00);
    tick;
    chk("in_ch0", 32'(rdata), 32'hFF);
    acc(0, 1, 1, 1, 8'h00);
    tick;
    chk("in_ch1", 32'(rdata), 32'hFF);

    for (int i = 0; i < 14; i++) begin
      acc(tbl[i].wr, tbl[i].rd, tbl[i].ch, tbl[i].rg, tbl[i].wd);
      tick;
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdx));
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].outx));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
    end

    // Drop all inputs: both channels flag, then clear them.
    acc(0, 0, 0, 0, 8'h00);
    in = 16'h0000;
    repeat (4) tick;
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("chg0_all", 32'(rdata), 32'hFF);
    acc(0, 1, 1, 2, 8'h00);
    tick;
    chk("chg1_all", 32'(rdata), 32'hFF);
    chk("irq_unmasked", 32'(irq), 32'h0);
    acc(1, 0, 0, 2, 8'hFF);
    tick;
    acc(1, 0, 1, 2, 8'hFF);
    tick;
    acc(1, 0, 0, 3, 8'h01);
    tick;
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("chg0_cleared", 32'(rdata), 32'h00);
    acc(0, 0, 0, 0, 8'h00);

    // Rising bit0: flag at 3 cycles, irq one later.
    in = 16'h0001;
    tick;
    tick;
    chk("det_irq_e2", 32'(irq), 32'h0);
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("det_chg_e3", 32'(rdata), 32'h00);
    chk("det_irq_e3", 32'(irq), 32'h0);
    tick;
    chk("det_chg_e4", 32'(rdata), 32'h01);
    chk("det_irq_e4", 32'(irq), 32'h1);
    acc(0, 0, 0, 0, 8'h00);

    // Clear bit0 in the same cycle a new toggle lands on it.
    in = 16'h0000;
    tick;
    tick;
    acc(1, 0, 0, 2, 8'h01);
    tick;
    chk("coll_irq_a", 32'(irq), 32'h1);
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("coll_chg", 32'(rdata), 32'h01);
    chk("coll_irq_b", 32'(irq), 32'h1);

    // Plain W1C drops irq two cycles after the write.
    acc(1, 0, 0, 2, 8'h01);
    tick;
    chk("w1c_irq_1", 32'(irq), 32'h1);
    acc(0, 0, 0, 0, 8'h00);
    tick;
    chk("w1c_irq_2", 32'(irq), 32'h0);
    acc(0, 1, 0, 2, 8'h00);
    tick;
    chk("w1c_chg", 32'(rdata), 32'h00);
    acc(0, 0, 0, 0, 8'h00);

    // Three-channel instance: channel 3 is out of range.
    p_wr = 1'b1;
    p_ch = 2'd2;
    p_rg = 2'd0;
    p_wd = 4'hA;
    tick;
    chk("p3_out_ch2", 32'(p_out), 32'hA00);
    p_wr = 1'b0;
    p_rd = 1'b1;
    tick;
    chk("p3_rd_ch2", 32'(p_rdata), 32'hA);
    p_rd = 1'b0;
    p_wr = 1'b1;
    p_ch = 2'd3;
    p_wd = 4'hF;
    tick;
    chk("p3_out_oor", 32'(p_out), 32'hA00);
    p_wr = 1'b0;
    p_rd = 1'b1;
    tick;
    chk("p3_rvalid_oor", 32'(p_rvalid), 32'h1);
    chk("p3_rdata_oor", 32'(p_rdata), 32'h0);
    p_rd = 1'b0;
    tick;
    chk("p3_out_final", 32'(p_out), 32'hA00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
